wb_mem_arbiter: RTL

Round-robin Wishbone arbiter that shares the single DRAM master port between the instruction cache and the data cache. Each grant covers exactly one transaction and is followed by a mandatory one-cycle bus release. A per-grant watchdog retires transactions the DRAM never acknowledges by returning RTY to the owning cache. The block sits between the two cache miss/writeback ports and the DRAM Wishbone slave.

---
 rtl/wb_mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone arbiter sharing one DRAM master port between the
// instruction and data caches, with a per-grant watchdog that retires hung transfers.
`timescale 1ns/1ps
module wb_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    // Handshake: a cache requests with CYC=1 and STB=1 and holds its request
    // until it sees ACK or RTY; dropping CYC while granted aborts the transfer.
    input  logic         icache_cyc,
    input  logic         icache_stb,
    input  logic         icache_we,
    input  logic [31:0]  icache_adr,
    input  logic [15:0]  icache_sel,
    input  logic [127:0] icache_dat_m,
    output logic [127:0] icache_dat_s,
    output logic         icache_ack,
    output logic         icache_rty,
    input  logic         dcache_cyc,
    input  logic         dcache_stb,
    input  logic         dcache_we,
    input  logic [31:0]  dcache_adr,
    input  logic [15:0]  dcache_sel,
    input  logic [127:0] dcache_dat_m,
    output logic [127:0] dcache_dat_s,
    output logic         dcache_ack,
    output logic         dcache_rty,
    output logic         dram_cyc,
    output logic         dram_stb,
    output logic         dram_we,
    output logic [31:0]  dram_adr,
    output logic [15:0]  dram_sel,
    output logic [127:0] dram_dat_m,
    input  logic [127:0] dram_dat_s,
    input  logic         dram_ack,
    input  logic         dram_rty,
    output logic [1:0]   grant,
    output logic         timeout_err,
    output logic [1:0]   state_dbg
);

    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_I_BUS   = 2'd1,
        S_D_BUS   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;   // 0 = icache, 1 = dcache
    logic [WDOG_W-1:0]   wdog_q, wdog_d;

    logic         i_req, d_req, own_i, own_d;
    logic         x_cyc, x_stb, x_we;
    logic [31:0]  x_adr;
    logic [15:0]  x_sel;
    logic [127:0] x_dat;
    logic         fwd_ack, fwd_rty;
    logic [127:0] fwd_dat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    assign i_req = icache_cyc & icache_stb;
    assign d_req = dcache_cyc & dcache_stb;
    assign own_i = (state_q == S_I_BUS);
    assign own_d = (state_q == S_D_BUS);

    assign x_cyc = own_d ? dcache_cyc   : icache_cyc;
    assign x_stb = own_d ? dcache_stb   : icache_stb;
    assign x_we  = own_d ? dcache_we    : icache_we;
    assign x_adr = own_d ? dcache_adr   : icache_adr;
    assign x_sel = own_d ? dcache_sel   : icache_sel;
    assign x_dat = own_d ? dcache_dat_m : icache_dat_m;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wdog_d      = wdog_q;
        dram_cyc    = 1'b0;
        dram_stb    = 1'b0;
        dram_we     = 1'b0;
        dram_adr    = '0;
        dram_sel    = '0;
        dram_dat_m  = '0;
        fwd_ack     = 1'b0;
        fwd_rty     = 1'b0;
        fwd_dat     = '0;
        timeout_err = 1'b0;
        case (state_q)
            S_IDLE, S_RELEASE: begin
                wdog_d = '0;
                if (i_req && d_req) begin
                    state_d = last_q ? S_I_BUS : S_D_BUS;
                    last_d  = ~last_q;
                end else if (i_req) begin
                    state_d = S_I_BUS;
                    last_d  = 1'b0;
                end else if (d_req) begin
                    state_d = S_D_BUS;
                    last_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                dram_cyc   = x_cyc;
                dram_stb   = x_stb;
                dram_we    = x_we;
                dram_adr   = x_adr;
                dram_sel   = x_sel;
                dram_dat_m = x_dat;
                fwd_ack    = dram_ack;
                fwd_rty    = dram_rty;
                fwd_dat    = dram_dat_s;
                if (dram_ack || dram_rty) begin
                    state_d = S_RELEASE;
                end else if (!x_cyc) begin
                    state_d = S_IDLE;
                end else if (wdog_q == WDOG_MAX) begin
                    // DRAM never answered: drop the bus and tell the owner to retry.
                    dram_cyc    = 1'b0;
                    dram_stb    = 1'b0;
                    fwd_rty     = 1'b1;
                    timeout_err = 1'b1;
                    state_d     = S_RELEASE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
        endcase
    end

    assign icache_ack   = own_i & fwd_ack;
    assign icache_rty   = own_i & fwd_rty;
    assign icache_dat_s = own_i ? fwd_dat : '0;
    assign dcache_ack   = own_d & fwd_ack;
    assign dcache_rty   = own_d & fwd_rty;
    assign dcache_dat_s = own_d ? fwd_dat : '0;
    assign grant        = {own_d, own_i};
    assign state_dbg    = state_q;

endmodule
